// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - consumer-side reader draining a FIFO over a four-phase rx_rdy/rx_done handshake
module fifo_reader #(
    parameter int WIDTH   = 8,
    parameter int LEN_W   = 8,
    parameter int SUM_W   = 16,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] length,
    input  logic             rx_rdy,
    input  logic [WIDTH-1:0] out_data,
    output logic             rx_done,
    output logic             busy,
    output logic             finished,
    output logic             error,
    output logic [LEN_W-1:0] word_count,
    output logic [WIDTH-1:0] last_data,
    output logic [SUM_W-1:0] checksum
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_RDY, S_ACK, S_DONE} state_e;

    state_e             state_q, state_d;
    logic               rx_done_q, rx_done_d;
    logic               busy_q, busy_d;
    logic               finished_q, finished_d;
    logic               error_q, error_d;
    logic [LEN_W-1:0]   word_count_q, word_count_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [WIDTH-1:0]   last_data_q, last_data_d;
    logic [SUM_W-1:0]   checksum_q, checksum_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    always_comb begin
        state_d      = state_q;
        rx_done_d    = rx_done_q;
        error_d      = error_q;
        word_count_d = word_count_q;
        len_d        = len_q;
        last_data_d  = last_data_q;
        checksum_d   = checksum_q;
        tmo_d        = tmo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    word_count_d = '0;
                    checksum_d   = '0;
                    error_d      = 1'b0;
                    len_d        = length;
                    state_d      = (length == '0) ? S_DONE : S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (rx_rdy) begin
                    last_data_d  = out_data;
                    checksum_d   = checksum_q + SUM_W'(out_data);
                    word_count_d = word_count_q + LEN_W'(1);
                    rx_done_d    = 1'b1;
                    tmo_d        = '0;
                    state_d      = S_ACK;
                end
            end
            S_ACK: begin
                if (!rx_rdy) begin
                    rx_done_d = 1'b0;
                    state_d   = (word_count_q == len_q) ? S_DONE : S_WAIT_RDY;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    // The counter reaching TIMEOUT on this edge aborts; the word stays counted.
                    if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        error_d   = 1'b1;
                        rx_done_d = 1'b0;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d != S_IDLE);
        finished_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rx_done_q    <= 1'b0;
            busy_q       <= 1'b0;
            finished_q   <= 1'b0;
            error_q      <= 1'b0;
            word_count_q <= '0;
            len_q        <= '0;
            last_data_q  <= '0;
            checksum_q   <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            rx_done_q    <= rx_done_d;
            busy_q       <= busy_d;
            finished_q   <= finished_d;
            error_q      <= error_d;
            word_count_q <= word_count_d;
            len_q        <= len_d;
            last_data_q  <= last_data_d;
            checksum_q   <= checksum_d;
            tmo_q        <= tmo_d;
        end
    end

    assign rx_done    = rx_done_q;
    assign busy       = busy_q;
    assign finished   = finished_q;
    assign error      = error_q;
    assign word_count = word_count_q;
    assign last_data  = last_data_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - scoreboard bench for fifo_reader with a four-phase FIFO model
module tb_fifo_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] length;
    logic       rx_rdy;
    logic [7:0] out_data;
    logic       rx_done;
    logic       busy;
    logic       finished;
    logic       error;
    logic [7:0] word_count;
    logic [7:0] last_data;
    logic [7:0] checksum;

    fifo_reader #(.WIDTH(8), .LEN_W(8), .SUM_W(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .length(length),
        .rx_rdy(rx_rdy), .out_data(out_data), .rx_done(rx_done),
        .busy(busy), .finished(finished), .error(error),
        .word_count(word_count), .last_data(last_data), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // mode 0: inputs driven by hand, 1: FIFO model drives, 2: rx_rdy held high by hand
    int         mode = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] sb_q[$];
    int         phase = 0;
    int         delay = 0;
    int         max_delay = 0;
    int         rises = 0;
    int         fin_cnt = 0;
    int         done_hi = 0;
    int         viol = 0;
    logic       prev_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Monitor and FIFO model share one process so the monitor sees the rx_rdy the DUT just sampled.
    always @(posedge clk) begin
        #1;
        if (rx_done && !prev_done) begin
            rises++;
            if (!rx_rdy) viol++;
            if (sb_q.size() == 0) check("sb_underflow", 1, 0);
            else check("sb_data", {24'h0, last_data}, {24'h0, sb_q.pop_front()});
        end
        if (!rx_done && prev_done && rx_rdy && !error && !rst) viol++;
        if (rx_done) done_hi++;
        if (finished) fin_cnt++;
        prev_done = rx_done;

        if (mode == 1) begin
            if (rx_rdy && rx_done) begin
                void'(fifo_q.pop_front());
                rx_rdy = 1'b0;
                phase  = 1;
            end else if (phase == 1) begin
                if (!rx_done) begin
                    phase = 0;
                    delay = $urandom_range(max_delay, 0);
                end
            end else if (!rx_rdy && fifo_q.size() > 0) begin
                if (delay > 0) delay--;
                else begin
                    rx_rdy   = 1'b1;
                    out_data = fifo_q[0];
                end
            end
        end
    end

    task automatic preload(input logic [7:0] w);
        fifo_q.push_back(w);
        sb_q.push_back(w);
    endtask

    task automatic clear_counts();
        rises = 0; fin_cnt = 0; done_hi = 0;
    endtask

    task automatic do_cmd(input logic [7:0] len);
        @(negedge clk);
        start  = 1'b1;
        length = len;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (busy) check({tag, "_idle_timeout"}, 1, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; length = 8'd0;
        rx_rdy = 1'b1; out_data = 8'($urandom);

        // Reset with an active FIFO
        repeat (2) begin
            @(negedge clk);
            out_data = 8'($urandom);
        end
        check("rst_rx_done", {31'h0, rx_done}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_finished", {31'h0, finished}, 0);
        check("rst_error", {31'h0, error}, 0);
        check("rst_counts", {8'h0, word_count, last_data, checksum}, 0);
        check("rst_no_rise", rises, 0);
        rst = 1'b0; rx_rdy = 1'b0; mode = 1;

        // Basic read of five words
        clear_counts();
        max_delay = 0;
        for (int i = 1; i <= 5; i++) preload(8'(i * 10));
        do_cmd(8'd5);
        check("basic_busy", {31'h0, busy}, 1);
        wait_idle("basic");
        check("basic_count", word_count, 5);
        check("basic_sum", checksum, 150);
        check("basic_last", last_data, 50);
        check("basic_fin", fin_cnt, 1);
        check("basic_err", {31'h0, error}, 0);
        check("basic_empty", fifo_q.size(), 0);
        check("basic_rises", rises, 5);

        // Back-pressure with wrapping checksum
        clear_counts();
        max_delay = 7;
        delay = $urandom_range(7, 0);
        repeat (4) preload(8'hFF);
        do_cmd(8'd4);
        wait_idle("bp");
        check("bp_count", word_count, 4);
        check("bp_sum", checksum, 8'hFC);
        check("bp_last", last_data, 8'hFF);
        check("bp_fin", fin_cnt, 1);
        check("bp_handshake", viol, 0);

        // Zero length
        clear_counts();
        do_cmd(8'd0);
        check("zero_busy1", {31'h0, busy}, 1);
        check("zero_fin1", {31'h0, finished}, 1);
        @(negedge clk);
        check("zero_busy2", {31'h0, busy}, 0);
        check("zero_fin2", {31'h0, finished}, 0);
        check("zero_counts", {16'h0, word_count, checksum}, 0);
        check("zero_rises", rises, 0);
        check("zero_fin_cnt", fin_cnt, 1);

        // Timeout: rx_rdy stuck high
        clear_counts();
        @(negedge clk);
        mode = 2; rx_rdy = 1'b1; out_data = 8'h5A;
        sb_q.push_back(8'h5A);
        do_cmd(8'd3);
        wait_idle("tmo");
        check("tmo_done_cycles", done_hi, 4);
        check("tmo_error", {31'h0, error}, 1);
        check("tmo_count", word_count, 1);
        check("tmo_sum", checksum, 8'h5A);
        check("tmo_fin", fin_cnt, 1);
        @(negedge clk);
        mode = 1; rx_rdy = 1'b0; phase = 0; delay = 0;
        do_cmd(8'd0);
        wait_idle("tmo_clr");
        check("tmo_err_cleared", {31'h0, error}, 0);

        // Start ignored during ACK, then reset mid-handshake
        clear_counts();
        @(negedge clk);
        mode = 2; rx_rdy = 1'b1; out_data = 8'h33;
        sb_q.push_back(8'h33);
        do_cmd(8'd2);
        begin
            int n;
            n = 0;
            while (!rx_done && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("mid_ack_seen", {31'h0, rx_done}, 1);
        end
        start = 1'b1; length = 8'd7;
        @(negedge clk);
        start = 1'b0;
        check("mid_busy", {31'h0, busy}, 1);
        check("mid_ack_held", {31'h0, rx_done}, 1);
        check("mid_count", word_count, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_done", {31'h0, rx_done}, 0);
        check("mid_rst_busy", {31'h0, busy}, 0);
        check("mid_rst_count", word_count, 0);
        rst = 1'b0; mode = 1; rx_rdy = 1'b0; phase = 0; delay = 0; max_delay = 0;
        fifo_q.delete();
        clear_counts();
        preload(8'h11);
        preload(8'h22);
        do_cmd(8'd2);
        wait_idle("fresh");
        check("fresh_count", word_count, 2);
        check("fresh_sum", checksum, 8'h33);
        check("fresh_last", last_data, 8'h22);
        check("fresh_err", {31'h0, error}, 0);
        check("fresh_rises", rises, 2);
        check("sb_drained", sb_q.size(), 0);
        check("handshake_total", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
